// File: rtl/rf_pkg.sv
// Shared types and default sizing for the parametrised register file.
package rf_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  localparam int unsigned RF_DATA_WIDTH = 16;
  localparam int unsigned RF_DEPTH      = 64;
  localparam int unsigned RF_NUM_READ   = 2;

  // Address width for a given depth; a depth of 1 still needs one address bit.
  function automatic int unsigned rf_addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/param_register_file_if.sv
// Write/read bus of the register file: writeback drives the write side,
// decode drives the read addresses, the ALU consumes ReadData.
interface param_register_file_if
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned DEPTH      = RF_DEPTH,
  parameter int unsigned NUM_READ   = RF_NUM_READ
);

  localparam int unsigned AW = rf_addr_width(DEPTH);

  logic                                WriteEnable;
  logic [AW-1:0]                       WriteAddress;
  logic [DATA_WIDTH-1:0]               WriteData;
  logic [NUM_READ-1:0][AW-1:0]         ReadAddress;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0] ReadData;
  logic                                Busy;

  modport master (
    output WriteEnable, WriteAddress, WriteData, ReadAddress,
    input  ReadData, Busy
  );

  modport slave (
    input  WriteEnable, WriteAddress, WriteData, ReadAddress,
    output ReadData, Busy
  );

endinterface

// File: rtl/rf_read_port.sv
// One registered read port: range check, optional write forwarding, output register.
// Macro RF_WRITE_BYPASS_EN: when defined, a same-cycle write to the address
// being read is forwarded to the output; otherwise the old contents are returned.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned DEPTH      = RF_DEPTH,
  parameter int unsigned AW         = rf_addr_width(RF_DEPTH)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ready_i,
  input  logic [AW-1:0]         raddr_i,
  input  logic [DATA_WIDTH-1:0] rdata_raw_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic                  in_range;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign in_range = ({1'b0, raddr_i} < DEPTH_L);

`ifdef RF_WRITE_BYPASS_EN
  // Select stored data, forwarding a same-cycle write (wr_en_i is only ever in range).
  always_comb begin
    rdata_d = '0;
    if (in_range) begin
      rdata_d = rdata_raw_i;
      if (wr_en_i && (wr_addr_i == raddr_i)) begin
        rdata_d = wr_data_i;
      end
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};

  // Select stored data; out-of-range addresses read as zero.
  always_comb begin
    rdata_d = '0;
    if (in_range) begin
      rdata_d = rdata_raw_i;
    end
  end
`endif

  // Output register, forced to zero during reset and the clear sweep.
  always_ff @(posedge Clock) begin
    if (Reset || !ready_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: one write port, NUM_READ registered read ports,
// hardware clear sweep after reset (Busy high while it runs).
// Macro RF_WRITE_BYPASS_EN selects same-cycle write forwarding in the read ports.
module param_register_file
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned DEPTH      = RF_DEPTH,
  parameter int unsigned NUM_READ   = RF_NUM_READ
) (
  input  logic                 Clock,
  input  logic                 Reset,
  param_register_file_if.slave rf
);

  localparam int unsigned  AW      = rf_addr_width(DEPTH);
  localparam logic [AW:0]  DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  rf_state_t             state_q, state_d;
  logic [AW-1:0]         clear_ptr_q, clear_ptr_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];

  logic                  ready;
  logic                  wr_in_range;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] raw [NUM_READ];
  logic [DATA_WIDTH-1:0] rdata [NUM_READ];

  assign ready       = (state_q == RF_READY);
  assign wr_in_range = ({1'b0, rf.WriteAddress} < DEPTH_L);
  assign wr_commit   = ready && rf.WriteEnable && wr_in_range;
  assign rf.Busy     = (state_q == RF_CLEAR);

  // State and sweep pointer; reset restarts the sweep from entry 0.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= RF_CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  // Clear sweep: advance one entry per cycle, leave after the last entry.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    if (state_q == RF_CLEAR) begin
      clear_ptr_d = clear_ptr_q + AW'(1);
      if (clear_ptr_q == LAST) begin
        state_d     = RF_READY;
        clear_ptr_d = '0;
      end
    end
  end

  // Storage: sweep writes zero, otherwise the write port updates in-range entries.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (state_q == RF_CLEAR) begin
        regs_q[clear_ptr_q] <= '0;
      end else if (wr_commit) begin
        regs_q[rf.WriteAddress] <= rf.WriteData;
      end
    end
  end

  // Raw array lookup per read port; range masking happens in the port.
  always_comb begin
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      raw[i] = regs_q[rf.ReadAddress[i]];
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_port
    rf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
    ) u_port (
      .Clock       (Clock),
      .Reset       (Reset),
      .ready_i     (ready),
      .raddr_i     (rf.ReadAddress[g]),
      .rdata_raw_i (raw[g]),
      .wr_en_i     (wr_commit),
      .wr_addr_i   (rf.WriteAddress),
      .wr_data_i   (rf.WriteData),
      .rdata_o     (rdata[g])
    );
  end

  // Pack per-port registers onto the bus.
  always_comb begin
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      rf.ReadData[i] = rdata[i];
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: a 64-entry file (A) and a 40-entry file (B).
// Read expectations are queued when the address is driven and checked one cycle later.
module tb_param_register_file;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_register_file_if #(.DATA_WIDTH(16), .DEPTH(64), .NUM_READ(2)) rf_a ();
  param_register_file_if #(.DATA_WIDTH(16), .DEPTH(40), .NUM_READ(2)) rf_b ();

  param_register_file #(.DATA_WIDTH(16), .DEPTH(64), .NUM_READ(2)) dut_a (
    .Clock (clk), .Reset (rst_a), .rf (rf_a)
  );
  param_register_file #(.DATA_WIDTH(16), .DEPTH(40), .NUM_READ(2)) dut_b (
    .Clock (clk), .Reset (rst_b), .rf (rf_b)
  );

  typedef struct {
    int          dut;
    int          port;
    logic [15:0] exp;
    int          due;
    string       tag;
  } sb_t;
  sb_t sb[$];
  sb_t ent;

  typedef struct {
    bit          we;
    int          wa;
    logic [15:0] wd;
    int          ra0;
    int          ra1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int dut, input int port, input int addr, input logic [15:0] exp,
                    input string tag);
    sb_t e;
    if (dut == 0) rf_a.ReadAddress[port] = 6'(addr);
    else          rf_b.ReadAddress[port] = 6'(addr);
    e.dut = dut; e.port = port; e.exp = exp; e.due = cyc + 1; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wr_a(input bit we, input int addr, input logic [15:0] data);
    rf_a.WriteEnable  = we;
    rf_a.WriteAddress = 6'(addr);
    rf_a.WriteData    = data;
  endtask

  task automatic wr_b(input bit we, input int addr, input logic [15:0] data);
    rf_b.WriteEnable  = we;
    rf_b.WriteAddress = 6'(addr);
    rf_b.WriteData    = data;
  endtask

  // Scoreboard: compare every entry whose data is due by now.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      ent = sb.pop_front();
      chk(ent.tag, (ent.dut == 0) ? 32'(rf_a.ReadData[ent.port]) : 32'(rf_b.ReadData[ent.port]),
          32'(ent.exp));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int na, nb, n;
    logic [15:0] byp_exp;

    tbl[0] = '{1'b1,  5, 16'hBEEF,  0,  1, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0,  0, 16'h0000,  5,  5, 16'hBEEF, 16'hBEEF};
    tbl[2] = '{1'b1, 63, 16'hCAFE,  5, 62, 16'hBEEF, 16'h0000};
    tbl[3] = '{1'b0,  0, 16'h0000, 63,  0, 16'hCAFE, 16'h0000};
    tbl[4] = '{1'b1,  0, 16'h0001, 63,  5, 16'hCAFE, 16'hBEEF};
    tbl[5] = '{1'b1,  9, 16'h1111,  0,  0, 16'h0001, 16'h0001};
    tbl[6] = '{1'b0,  0, 16'h0000,  9, 63, 16'h1111, 16'hCAFE};
    tbl[7] = '{1'b0,  5, 16'hDEAD,  5,  9, 16'hBEEF, 16'h1111};
    tbl[8] = '{1'b1, 62, 16'h7E57,  1,  0, 16'h0000, 16'h0001};

    rst_a = 1'b1; rst_b = 1'b1;
    wr_a(1'b0, 0, 16'h0); wr_b(1'b0, 0, 16'h0);
    rf_a.ReadAddress = '0; rf_b.ReadAddress = '0;
    step();
    chk("reset_rdata_a", 32'(rf_a.ReadData), 32'h0);
    chk("reset_busy_a", 32'(rf_a.Busy), 32'h1);
    rst_a = 1'b0; rst_b = 1'b0;

    // Sweep: count Busy cycles while hammering writes that must be ignored.
    na = 0; nb = 0; n = 0;
    while ((rf_a.Busy || rf_b.Busy) && n < 500) begin
      if (rf_a.Busy) na++;
      if (rf_b.Busy) nb++;
      n++;
      wr_a(rf_a.Busy, 3, 16'hAAAA);
      wr_b(rf_b.Busy, 3, 16'hBBBB);
      rd(0, 0, 3, 16'h0000, "busy_rd_a");
      step();
    end
    chk("busy_len_a", 32'(na), 32'd64);
    chk("busy_len_b", 32'(nb), 32'd40);
    wr_a(1'b0, 0, 16'h0); wr_b(1'b0, 0, 16'h0);

    // Every entry reads zero after the sweep, including the one written while busy.
    for (int a = 0; a < 64; a += 2) begin
      rd(0, 0, a, 16'h0000, "clear_a");
      rd(0, 1, a + 1, 16'h0000, "clear_a");
      if (a < 40) begin
        rd(1, 0, a, 16'h0000, "clear_b");
        rd(1, 1, a + 1, 16'h0000, "clear_b");
      end
      step();
    end

    // Table of write/read cycles on file A.
    for (int i = 0; i < 9; i++) begin
      wr_a(tbl[i].we, tbl[i].wa, tbl[i].wd);
      rd(0, 0, tbl[i].ra0, tbl[i].e0, $sformatf("tbl%0d_p0", i));
      rd(0, 1, tbl[i].ra1, tbl[i].e1, $sformatf("tbl%0d_p1", i));
      step();
    end

    // Same-cycle write and read of entry 9.
`ifdef RF_WRITE_BYPASS_EN
    byp_exp = 16'h2222;
`else
    byp_exp = 16'h1111;
`endif
    wr_a(1'b1, 9, 16'h2222);
    rd(0, 0, 9, byp_exp, "rw_same_cycle");
    rd(0, 1, 62, 16'h7E57, "rw_other_port");
    step();
    wr_a(1'b0, 0, 16'h0);
    rd(0, 0, 9, 16'h2222, "rw_next_p0");
    rd(0, 1, 9, 16'h2222, "rw_next_p1");
    step();

    // Non-power-of-2 depth: out-of-range writes dropped, reads zero, never forwarded.
    wr_b(1'b1, 45, 16'h5555);
    rd(1, 0, 45, 16'h0000, "oor_same_cycle");
    rd(1, 1, 39, 16'h0000, "b39_before");
    step();
    wr_b(1'b1, 39, 16'h0F0F);
    rd(1, 0, 45, 16'h0000, "oor_after_wr");
    rd(1, 1, 0, 16'h0000, "b0_untouched");
    step();
    wr_b(1'b0, 0, 16'h0);
    rd(1, 0, 39, 16'h0F0F, "b39_last");
    rd(1, 1, 45, 16'h0000, "oor_read");
    step();

    // Reset mid-operation and again mid-sweep.
    wr_a(1'b1, 7, 16'h1234);
    rd(0, 0, 9, 16'h2222, "pre_rst_p0");
    step();
    wr_a(1'b0, 0, 16'h0);
    rd(0, 0, 7, 16'h1234, "pre_rst_wr7");
    step();
    rst_a = 1'b1;
    rd(0, 0, 7, 16'h0000, "rst_forces_zero_p0");
    rd(0, 1, 9, 16'h0000, "rst_forces_zero_p1");
    step();
    rst_a = 1'b0;
    repeat (30) step();
    chk("busy_mid_sweep", 32'(rf_a.Busy), 32'h1);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    na = 0; n = 0;
    while (rf_a.Busy && n < 500) begin
      na++; n++;
      step();
    end
    chk("busy_len_restart", 32'(na), 32'd64);
    rd(0, 0, 7, 16'h0000, "post_rst_rd7");
    rd(0, 1, 9, 16'h0000, "post_rst_rd9");
    step();

    repeat (2) step();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
